// File: rtl/td4_regscan_if.sv
// Register-view port and ASCII character stream shared by td4_regscan and its neighbours.
// The master side is the scanner: it drives the register select and the character stream.
interface td4_regscan_if;
  logic [2:0] regsel;
  logic [7:0] regdat;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       char_first;

  modport master (
    output regsel,
    input  regdat,
    output char_data,
    output char_valid,
    output char_first,
    input  char_ready
  );

  modport slave (
    input  regsel,
    output regdat,
    input  char_data,
    input  char_valid,
    input  char_first,
    output char_ready
  );
endinterface

// File: rtl/td4_regscan.sv
// Register-view scanner: on each refresh tick, walks regsel over NREGS registers, captures each
// byte after a settle interval and emits label / hex-high / hex-low characters on a
// valid/ready stream.
module td4_regscan #(
  parameter int unsigned NREGS       = 7,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned REFRESH_DIV = 500000
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               enable,
  td4_regscan_if.master      bus,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);

  typedef enum logic [2:0] {StIdle, StSelect, StSendLbl, StSendHi, StSendLo} state_e;

  state_e          state_q, state_d;
  logic [2:0]      regsel_q, regsel_d;
  logic [3:0]      settle_q, settle_d;
  logic [7:0]      cap_q, cap_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic            tick;

  function automatic logic [7:0] label_char(input logic [2:0] sel);
    logic [7:0] c;
    unique case (sel)
      3'd0: c = 8'h50;  // P
      3'd1: c = 8'h41;  // A
      3'd2: c = 8'h42;  // B
      3'd3: c = 8'h53;  // S
      3'd4: c = 8'h46;  // F
      3'd5: c = 8'h4F;  // O
      3'd6: c = 8'h49;  // I
      default: c = 8'h58;  // X
    endcase
    return c;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Refresh timer: free-runs while enabled, holds otherwise; tick on the terminal count.
  always_comb begin
    tick  = enable && (cnt_q == CntW'(REFRESH_DIV - 1));
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  // Frame sequencing; ticks that arrive while busy collapse into the single pending flag.
  always_comb begin
    state_d   = state_q;
    regsel_d  = regsel_q;
    settle_d  = settle_q;
    cap_d     = cap_q;
    pending_d = pending_q | tick;
    unique case (state_q)
      StIdle: begin
        if (pending_q || tick) begin
          state_d   = StSelect;
          regsel_d  = '0;
          settle_d  = '0;
          pending_d = 1'b0;
        end
      end
      StSelect: begin
        if (settle_q == 4'(SETTLE - 1)) begin
          cap_d   = bus.regdat;
          state_d = StSendLbl;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StSendLbl: begin
        if (bus.char_ready) state_d = StSendHi;
      end
      StSendHi: begin
        if (bus.char_ready) state_d = StSendLo;
      end
      StSendLo: begin
        if (bus.char_ready) begin
          if (regsel_q < 3'(NREGS - 1)) begin
            regsel_d = regsel_q + 3'd1;
            settle_d = '0;
            state_d  = StSelect;
          end else begin
            regsel_d = '0;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from registered state so they hold steady while the sink stalls.
  always_comb begin
    bus.regsel     = regsel_q;
    bus.char_valid = 1'b0;
    bus.char_first = 1'b0;
    bus.char_data  = 8'h00;
    busy           = (state_q != StIdle);
    unique case (state_q)
      StSendLbl: begin
        bus.char_valid = 1'b1;
        bus.char_first = (regsel_q == 3'd0);
        bus.char_data  = label_char(regsel_q);
      end
      StSendHi: begin
        bus.char_valid = 1'b1;
        bus.char_data  = hex_char(cap_q[7:4]);
      end
      StSendLo: begin
        bus.char_valid = 1'b1;
        bus.char_data  = hex_char(cap_q[3:0]);
      end
      default: ;
    endcase
  end

  // State registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      regsel_q  <= '0;
      settle_q  <= '0;
      cap_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      regsel_q  <= regsel_d;
      settle_q  <= settle_d;
      cap_q     <= cap_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_td4_regscan.sv
// Directed bench for td4_regscan: table of per-register expected characters plus
// hand-written sequences for stall, back-to-back frames, mid-frame reset and enable drop.
module tb_td4_regscan;

  typedef struct {
    logic [7:0] lbl;
    logic [7:0] dat_b;
    logic [7:0] hi_b;
    logic [7:0] lo_b;
  } reg_vec_t;

  typedef struct {
    logic [7:0] d;
    logic       f;
    int         e;
  } xfer_t;

  logic CLOCK = 1'b0;
  logic RESET_N;
  logic enable;
  logic busy;
  logic mode;

  td4_regscan_if bus_if ();

  td4_regscan #(
    .NREGS(7),
    .SETTLE(2),
    .REFRESH_DIV(8)
  ) dut (
    .CLOCK(CLOCK),
    .RESET_N(RESET_N),
    .enable(enable),
    .bus(bus_if.master),
    .busy(busy)
  );

  always #5 CLOCK = ~CLOCK;

  reg_vec_t tbl [8];
  xfer_t    xq [$];
  int       first_q [$];
  int       edge_cnt = 0;
  logic     first_seen = 1'b0;
  int       n_vec = 0;
  int       n_err = 0;
  int       base;
  bit       stalled;

  // CPU side: mode 0 returns a constant byte, mode 1 a per-register byte.
  always_comb bus_if.regdat = mode ? tbl[bus_if.regsel].dat_b : 8'h3C;

  always @(posedge CLOCK) edge_cnt <= edge_cnt + 1;

  // Record transfers (at the coming edge) and the edge each frame's first character appears.
  always @(negedge CLOCK) begin
    if (bus_if.char_valid && bus_if.char_ready)
      xq.push_back('{d: bus_if.char_data, f: bus_if.char_first, e: edge_cnt + 1});
    if (bus_if.char_valid && bus_if.char_first && !first_seen) first_q.push_back(edge_cnt + 1);
    first_seen <= bus_if.char_valid && bus_if.char_first;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_chars(input int n, input int budget, input string name);
    for (int i = 0; i < budget && xq.size() < n; i++) step();
    chk(name, int'(xq.size() >= n), 1);
  endtask

  task automatic wait_first(input int budget, input string name);
    for (int i = 0; i < budget && first_q.size() == 0; i++) step();
    if (first_q.size() == 0) chk(name, 0, 1);
    else chk(name, first_q[0] - base, 11);
  endtask

  task automatic check_frame(input int off, input bit m, input string tag);
    logic [7:0] hi, lo;
    if (xq.size() < off + 21) begin
      chk({tag, "_len"}, xq.size(), off + 21);
      return;
    end
    for (int r = 0; r < 7; r++) begin
      hi = m ? tbl[r].hi_b : 8'h33;
      lo = m ? tbl[r].lo_b : 8'h43;
      chk($sformatf("%s_lbl%0d", tag, r), xq[off + 3*r].d, tbl[r].lbl);
      chk($sformatf("%s_first%0d", tag, r), xq[off + 3*r].f, (r == 0) ? 1 : 0);
      chk($sformatf("%s_hi%0d", tag, r), xq[off + 3*r + 1].d, hi);
      chk($sformatf("%s_lo%0d", tag, r), xq[off + 3*r + 2].d, lo);
      chk($sformatf("%s_nf%0d", tag, r), int'(xq[off + 3*r + 1].f | xq[off + 3*r + 2].f), 0);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_regsel"}, bus_if.regsel, 0);
    chk({tag, "_valid"}, bus_if.char_valid, 0);
    chk({tag, "_data"}, bus_if.char_data, 0);
    chk({tag, "_first"}, bus_if.char_first, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    tbl[0] = '{lbl: 8'h50, dat_b: 8'hA5, hi_b: 8'h41, lo_b: 8'h35};
    tbl[1] = '{lbl: 8'h41, dat_b: 8'h0F, hi_b: 8'h30, lo_b: 8'h46};
    tbl[2] = '{lbl: 8'h42, dat_b: 8'h12, hi_b: 8'h31, lo_b: 8'h32};
    tbl[3] = '{lbl: 8'h53, dat_b: 8'h7E, hi_b: 8'h37, lo_b: 8'h45};
    tbl[4] = '{lbl: 8'h46, dat_b: 8'h00, hi_b: 8'h30, lo_b: 8'h30};
    tbl[5] = '{lbl: 8'h4F, dat_b: 8'h9B, hi_b: 8'h39, lo_b: 8'h42};
    tbl[6] = '{lbl: 8'h49, dat_b: 8'hF0, hi_b: 8'h46, lo_b: 8'h30};
    tbl[7] = '{lbl: 8'h58, dat_b: 8'h00, hi_b: 8'h30, lo_b: 8'h30};

    RESET_N = 1'b0;
    enable  = 1'b0;
    mode    = 1'b0;
    bus_if.char_ready = 1'b1;
    repeat (3) step();
    check_reset("rst");

    // A: constant data, first-char latency, then enable dropped as the frame starts.
    @(negedge CLOCK);
    base    = edge_cnt;
    RESET_N = 1'b1;
    enable  = 1'b1;
    wait_first(40, "a_latency");
    enable = 1'b0;
    wait_chars(21, 300, "a_wait");
    repeat (60) step();
    chk("a_count", xq.size(), 21);
    chk("a_busy", busy, 0);
    check_frame(0, 1'b0, "a");

    // B: per-register data, ready toggling; enable dropped late in frame 1 so exactly one
    // pending frame must follow, starting 1+SETTLE+1 edges after the final char.
    xq.delete();
    first_q.delete();
    mode   = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 2000 && xq.size() < 42; i++) begin
      step();
      bus_if.char_ready = ~bus_if.char_ready;
      if (enable && xq.size() >= 19) enable = 1'b0;
    end
    bus_if.char_ready = 1'b1;
    repeat (60) step();
    chk("b_count", xq.size(), 42);
    chk("b_busy", busy, 0);
    check_frame(0, 1'b1, "b1");
    check_frame(21, 1'b1, "b2");
    if (first_q.size() < 2 || xq.size() < 21) chk("b_gap_frames", first_q.size(), 2);
    else chk("b_gap", first_q[1] - xq[20].e, 4);

    // C: stall five cycles on reg 2's high nibble.
    xq.delete();
    first_q.delete();
    stalled = 1'b0;
    enable  = 1'b1;
    for (int i = 0; i < 600 && xq.size() < 21; i++) begin
      step();
      if (enable && first_q.size() > 0) enable = 1'b0;
      if (!stalled && xq.size() == 7) begin
        stalled = 1'b1;
        bus_if.char_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge CLOCK);
          chk($sformatf("c_valid%0d", j), bus_if.char_valid, 1);
          chk($sformatf("c_data%0d", j), bus_if.char_data, 8'h31);
          chk($sformatf("c_sel%0d", j), bus_if.regsel, 2);
          @(posedge CLOCK);
          #1;
        end
        bus_if.char_ready = 1'b1;
      end
    end
    chk("c_stalled", stalled, 1);
    repeat (40) step();
    chk("c_count", xq.size(), 21);
    check_frame(0, 1'b1, "c");

    // D: asynchronous reset between edges during reg 3's low nibble.
    xq.delete();
    first_q.delete();
    mode   = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 200 && xq.size() < 11; i++) step();
    chk("d_reach", xq.size(), 11);
    chk("d_sel3", bus_if.regsel, 3);
    chk("d_lo_valid", bus_if.char_valid, 1);
    #2;
    RESET_N = 1'b0;
    #1;
    check_reset("d_rst");
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    xq.delete();
    first_q.delete();
    base    = edge_cnt;
    RESET_N = 1'b1;
    wait_first(40, "d_latency");
    wait_chars(21, 300, "d_wait");
    check_frame(0, 1'b0, "d");
    enable = 1'b0;
    repeat (60) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
